// File: rtl/cbus_arbiter_if.sv
// cbus arbiter bus bundle: per-requester request/response arrays, the shared
// downstream request/response pair, and the ownership status outputs.
// Modport slave is the arbiter's view; modport master is the surrounding
// environment's view (cache masters plus the downstream bridge).
interface cbus_arbiter_if #(
    parameter int unsigned NUM_INPUTS = 2
);
    // 151-bit request beat: valid, is_write, size, addr, strobe, data, len, burst
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    // 66-bit response beat
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    cbus_req_t  ireqs  [NUM_INPUTS];
    cbus_resp_t iresps [NUM_INPUTS];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic [2:0] grant;
    logic       busy;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq,
        output grant,
        output busy
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq,
        input  grant,
        input  busy
    );
endinterface

// File: rtl/cbus_arbiter.sv
// cbus arbiter: N cache masters share one cbus. Two-state FSM (idle/busy);
// the owner keeps the bus until a response beat with ready=1 and last=1.
// Optional feature macro: CBUS_ARBITER_ROUND_ROBIN_EN selects round-robin
// arbitration with a 3-bit priority pointer; when undefined the lowest valid
// index wins (fixed priority). NUM_INPUTS must lie in 2..8.
module cbus_arbiter #(
    parameter int unsigned NUM_INPUTS = 2
) (
    input  logic          clk,
    input  logic          reset,
    cbus_arbiter_if.slave bus
);
    localparam int NIn = int'(NUM_INPUTS);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [2:0]            r_grant;
    logic [2:0]            w_grant_d;
    logic [NUM_INPUTS-1:0] w_valid;
    logic                  w_any_valid;
    logic [2:0]            w_winner;
    logic                  w_release;
    logic [2:0]            w_grant_inc;

`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
    logic [2:0]            r_ptr;
    logic [2:0]            w_ptr_d;
`endif

    // Gather request valids into a vector
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NIn; i++) begin
            w_valid[i] = bus.ireqs[i].valid;
        end
    end

    // Pick the winner among valid requesters
    always_comb begin
        w_any_valid = 1'b0;
        w_winner    = 3'd0;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
        // Scan ptr, ptr+1, ... modulo NIn; first valid index wins
        for (int k = 0; k < NIn; k++) begin
            for (int i = 0; i < NIn; i++) begin
                if (!w_any_valid && w_valid[i] && (((int'(r_ptr) + k) % NIn) == i)) begin
                    w_any_valid = 1'b1;
                    w_winner    = 3'(i);
                end
            end
        end
`else
        // Descending scan so the lowest valid index is written last
        for (int i = NIn - 1; i >= 0; i--) begin
            if (w_valid[i]) begin
                w_any_valid = 1'b1;
                w_winner    = 3'(i);
            end
        end
`endif
    end

    assign w_release   = (r_state == StBusy) && bus.oresp.ready && bus.oresp.last;
    assign w_grant_inc = (r_grant == 3'(NUM_INPUTS - 1)) ? 3'd0 : r_grant + 3'd1;

    // Next-state logic: grant on any valid in idle, release only on ready & last
    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
        w_ptr_d   = r_ptr;
`endif
        case (r_state)
            StIdle: begin
                if (w_any_valid) begin
                    w_state_d = StBusy;
                    w_grant_d = w_winner;
                end
            end
            StBusy: begin
                // Owner's valid is ignored here: the bus is held until the last beat
                if (w_release) begin
                    w_state_d = StIdle;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
                    w_ptr_d   = w_grant_inc;
`endif
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, grant and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_grant <= 3'd0;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
            r_ptr   <= 3'd0;
`endif
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
            r_ptr   <= w_ptr_d;
`endif
        end
    end

    // Combinational routing: owner <-> shared bus while busy, all-zero otherwise
    always_comb begin
        bus.oreq = '0;
        for (int i = 0; i < NIn; i++) begin
            bus.iresps[i] = '0;
        end
        if (r_state == StBusy) begin
            for (int i = 0; i < NIn; i++) begin
                if (r_grant == 3'(i)) begin
                    bus.oreq      = bus.ireqs[i];
                    bus.iresps[i] = bus.oresp;
                end
            end
        end
    end

    assign bus.grant = r_grant;
    assign bus.busy  = (r_state == StBusy);

`ifndef CBUS_ARBITER_ROUND_ROBIN_EN
    // Only the wrap value feeds the pointer; keep it referenced in fixed mode
    logic w_unused_inc;
    assign w_unused_inc = ^w_grant_inc;
`endif
endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter (2 requesters). Expected owners are
// queued when requests are driven and popped when the DUT takes ownership.
`timescale 1ns/1ps
module tb_cbus_arbiter;
    localparam int unsigned N = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_arbiter_if #(.NUM_INPUTS(N)) bus ();

    cbus_arbiter #(.NUM_INPUTS(N)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [150:0] r_req [N];
    logic [65:0]  r_resp;
    bit           r_owner;
    int           checks;
    int           failures;
    int           exp_grant_q[$];

    function automatic logic [150:0] mk_req(input logic valid, input logic wr,
                                            input logic [63:0] addr, input logic [7:0] len);
        return {valid, wr, 3'd3, addr, 8'hFF, ~addr, len, 2'b01};
    endfunction

    function automatic logic [65:0] mk_resp(input logic ready, input logic last,
                                            input logic [63:0] data);
        return {ready, last, data};
    endfunction

    task automatic check_eq(input string tag, input logic [150:0] obs, input logic [150:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        bus.ireqs[0] = r_req[0];
        bus.ireqs[1] = r_req[1];
        bus.oresp    = r_resp;
    endtask

    task automatic set_req(input bit idx, input logic [150:0] v);
        r_req[idx] = v;
        apply();
    endtask

    task automatic check_resps(input bit owned);
        check_eq("iresp0", 151'(bus.iresps[0]), (owned && r_owner == 1'b0) ? 151'(r_resp) : '0);
        check_eq("iresp1", 151'(bus.iresps[1]), (owned && r_owner == 1'b1) ? 151'(r_resp) : '0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, 151'(bus.busy), 151'(0));
        check_eq({tag, "_oreq"}, 151'(bus.oreq), '0);
        check_resps(1'b0);
    endtask

    // Wait (bounded) for ownership; it must take exactly one edge
    task automatic wait_grant();
        int lat;
        int exp_g;
        lat = 0;
        while (!bus.busy && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("grant_latency", 151'(lat), 151'(1));
        if (exp_grant_q.size() == 0) begin
            check_eq("scoreboard_empty", 151'(1), 151'(0));
        end else begin
            exp_g   = exp_grant_q.pop_front();
            r_owner = exp_g[0];
            check_eq("grant", 151'(bus.grant), 151'(exp_g));
            check_eq("oreq_pass", 151'(bus.oreq), r_req[r_owner]);
        end
    endtask

    // Serve a burst; bp inserts a ready=0,last=1 beat before each real beat
    task automatic serve(input int beats, input bit bp, input bit drop_valid);
        for (int b = 1; b <= beats; b++) begin
            if (bp) begin
                r_resp = mk_resp(1'b0, 1'b1, {$urandom, $urandom});
                apply();
                #1;
                check_resps(1'b1);
                tick();
                check_eq("bp_hold", 151'(bus.busy), 151'(1));
            end
            r_resp = mk_resp(1'b1, b == beats, {$urandom, $urandom});
            apply();
            #1;
            check_eq("oreq_beat", 151'(bus.oreq), r_req[r_owner]);
            check_resps(1'b1);
            tick();
            if (b == beats) check_eq("release", 151'(bus.busy), 151'(0));
            else            check_eq("hold", 151'(bus.busy), 151'(1));
        end
        r_resp = '0;
        apply();
        if (drop_valid) set_req(r_owner, mk_req(1'b0, 1'b0, 64'h0, 8'h0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        r_owner  = 1'b0;
        r_req[0] = '0;
        r_req[1] = '0;
        r_resp   = '0;
        apply();

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check_idle("reset");
        check_eq("reset_grant", 151'(bus.grant), 151'(0));
        reset = 1'b0;

        // Idle hygiene: stray response traffic must not leak or change state
        r_resp = mk_resp(1'b1, 1'b1, 64'hDEADBEEF);
        apply();
        for (int c = 0; c < 3; c++) begin
            #1;
            check_idle("idle");
            tick();
        end
        r_resp = '0;
        apply();

        // Single read from requester 1, 4 beats
        set_req(1'b1, mk_req(1'b1, 1'b0, 64'h1000, 8'd3));
        #1;
        check_eq("pre_grant_valid", 151'(bus.oreq.valid), 151'(0));
        exp_grant_q.push_back(1);
        wait_grant();
        serve(4, 1'b0, 1'b1);
        #1;
        check_idle("after_single");

        // Simultaneous: 0 first, then one idle cycle, then 1
        set_req(1'b0, mk_req(1'b1, 1'b1, 64'h2000, 8'd1));
        set_req(1'b1, mk_req(1'b1, 1'b0, 64'h3000, 8'd1));
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        wait_grant();
        serve(2, 1'b0, 1'b1);
        wait_grant();
        serve(2, 1'b0, 1'b1);

        // Continuous requests from both after a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1'b0, mk_req(1'b1, 1'b0, 64'h4000, 8'd0));
        set_req(1'b1, mk_req(1'b1, 1'b0, 64'h5000, 8'd0));
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
`else
        for (int t = 0; t < 4; t++) exp_grant_q.push_back(0);
`endif
        for (int t = 0; t < 4; t++) begin
            wait_grant();
            serve(1, 1'b0, 1'b0);
        end
        set_req(1'b0, mk_req(1'b0, 1'b0, 64'h0, 8'h0));
        set_req(1'b1, mk_req(1'b0, 1'b0, 64'h0, 8'h0));

        // Back-pressure, with the owner dropping valid mid-burst
        set_req(1'b0, mk_req(1'b1, 1'b1, 64'h6000, 8'd1));
        exp_grant_q.push_back(0);
        wait_grant();
        set_req(1'b0, mk_req(1'b0, 1'b1, 64'h6000, 8'd1));
        serve(2, 1'b1, 1'b1);
        tick();
        check_idle("after_bp");

        // Reset on beat 2 of an 8-beat burst
        set_req(1'b0, mk_req(1'b1, 1'b0, 64'h7000, 8'd7));
        exp_grant_q.push_back(0);
        wait_grant();
        r_resp = mk_resp(1'b1, 1'b0, 64'h11);
        apply();
        tick();
        r_resp = mk_resp(1'b1, 1'b0, 64'h22);
        apply();
        reset = 1'b1;
        tick();
        check_eq("rst_busy", 151'(bus.busy), 151'(0));
        check_eq("rst_grant", 151'(bus.grant), 151'(0));
        check_eq("rst_oreq_valid", 151'(bus.oreq.valid), 151'(0));
        reset  = 1'b0;
        r_resp = '0;
        set_req(1'b0, mk_req(1'b0, 1'b0, 64'h0, 8'h0));
        set_req(1'b1, mk_req(1'b1, 1'b0, 64'h8000, 8'd0));
        exp_grant_q.push_back(1);
        wait_grant();
        serve(1, 1'b0, 1'b1);

        check_eq("scoreboard_drained", 151'(exp_grant_q.size()), 151'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
